// File: rtl/pc_redirect_unit.sv
// PC / IF-ID owner at the end of the branch-decision path: redirects fetch on a
// taken branch, holds a Flush window to squash younger stages, honours load-use stalls.
module pc_redirect_unit #(
  parameter int unsigned          WIDTH        = 32,
  parameter logic [WIDTH-1:0]     RESET_PC     = '0,
  parameter int unsigned          FLUSH_CYCLES = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Stall,
  input  logic [31:0]      InstrIn,
  output logic [WIDTH-1:0] PC,
  output logic [31:0]      IFID_Instr,
  output logic [WIDTH-1:0] IFID_PCPlus4,
  output logic             IFID_Valid,
  output logic             Flush,
  output logic [15:0]      RedirectCount
);
  localparam int unsigned CW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] pcp4_q, pcp4_d;
  logic             valid_q, valid_d;
  logic [15:0]      rcnt_q, rcnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    rcnt_d  = rcnt_q;
    if (PCSrc) begin
      // A new redirect always restarts the window, even mid-flush.
      pc_d    = BranchTarget & ALIGN_MASK;
      instr_d = '0;
      pcp4_d  = '0;
      valid_d = 1'b0;
      state_d = FLUSH;
      cnt_d   = CW'(FLUSH_CYCLES - 1);
      if (rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
    end else if (Stall && state_q == RUN) begin
      // hold everything
    end else begin
      // Stalls during FLUSH come from wrong-path instructions, so advance anyway.
      pc_d    = pc_q + PC_STEP;
      instr_d = InstrIn;
      pcp4_d  = pc_q + PC_STEP;
      valid_d = 1'b1;
      if (state_q == FLUSH) begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign PC            = pc_q;
  assign IFID_Instr    = instr_q;
  assign IFID_PCPlus4  = pcp4_q;
  assign IFID_Valid    = valid_q;
  assign Flush         = (state_q == FLUSH);
  assign RedirectCount = rcnt_q;
endmodule
